// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit packed-BCD adder that reuses one digit-add stage over DIGITS cycles, LSD first.
// Optional macro BCD_INVALID_CHECK_EN adds a sticky invalid-digit flag reported on err.
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout
`ifdef BCD_INVALID_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns {carry, digit}; invalid digits are not corrected, only the 5-bit sum is range-folded.
    function automatic logic [4:0] digit_add(input logic [3:0] da, input logic [3:0] db, input logic c);
        logic [4:0] t;
        logic [4:0] tm;
        t  = {1'b0, da} + {1'b0, db} + {4'b0000, c};
        tm = t - 5'd10;
        if (t > 5'd9) begin
            digit_add = {1'b1, tm[3:0]};
        end else begin
            digit_add = {1'b0, t[3:0]};
        end
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic            accept_s;
    logic            last_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            carry_r;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    work_r;
    logic [4:0]      stage_s;
    logic [W+3:0]    cat_s;
    logic [W-1:0]    work_next_s;

    assign stage_s     = digit_add(a_r[3:0], b_r[3:0], carry_r);
    // New digit enters at the top so that after DIGITS shifts digit 0 sits in [3:0].
    assign cat_s       = {stage_s[3:0], work_r};
    assign work_next_s = cat_s[W+3:4];
    assign last_s      = (cnt_r == CW'(DIGITS - 1));

`ifdef BCD_INVALID_CHECK_EN
    logic inv_r;
    logic inv_digit_s;
    assign inv_digit_s = (a_r[3:0] > 4'd9) || (b_r[3:0] > 4'd9);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and start acceptance.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture, per-digit datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            work_r  <= '0;
`ifdef BCD_INVALID_CHECK_EN
            inv_r   <= 1'b0;
            err     <= 1'b0;
`endif
        end else begin
            busy <= (state_next_s == ST_RUN);
            done <= (state_next_s == ST_DONE);
            if (accept_s) begin
                a_r     <= a;
                b_r     <= b;
                carry_r <= cin;
                cnt_r   <= '0;
                work_r  <= '0;
`ifdef BCD_INVALID_CHECK_EN
                inv_r   <= 1'b0;
`endif
            end else if (state_r == ST_RUN) begin
                a_r     <= a_r >> 3'd4;
                b_r     <= b_r >> 3'd4;
                carry_r <= stage_s[4];
                cnt_r   <= cnt_r + CW'(1);
                work_r  <= work_next_s;
`ifdef BCD_INVALID_CHECK_EN
                inv_r   <= inv_r | inv_digit_s;
`endif
                if (last_s) begin
                    sum  <= work_next_s;
                    cout <= stage_s[4];
`ifdef BCD_INVALID_CHECK_EN
                    err  <= inv_r | inv_digit_s;
`endif
                end else begin
                    sum  <= sum;
                    cout <= cout;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench: decimal-arithmetic reference model compared every cycle, plus literal checks.
module tb_bcd_serial_adder_ctrl;

    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [4*D-1:0] a;
    logic [4*D-1:0] b;
    logic           cin;
    logic           busy;
    logic           done;
    logic [4*D-1:0] sum;
    logic           cout;
`ifdef BCD_INVALID_CHECK_EN
    logic           err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef BCD_INVALID_CHECK_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: treat operands as decimal numbers and add them.
    function automatic logic [4*D:0] ref_add(input logic [4*D-1:0] x, input logic [4*D-1:0] y, input logic c);
        longint vx, vy, tot, lim;
        logic [4*D-1:0] r;
        vx = 0; vy = 0; lim = 1;
        for (int i = D - 1; i >= 0; i--) begin
            vx = vx * 10 + longint'(x[4*i +: 4]);
            vy = vy * 10 + longint'(y[4*i +: 4]);
            lim = lim * 10;
        end
        tot = vx + vy + longint'(c);
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((tot % lim) / (lim / 10) >= 0 ? ((tot % lim) / longint'(10 ** i)) % 10 : 0);
        end
        ref_add = {(tot >= lim), r};
    endfunction

    function automatic logic any_invalid(input logic [4*D-1:0] x, input logic [4*D-1:0] y);
        any_invalid = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) any_invalid = 1'b1;
        end
    endfunction

    // Protocol model: one accepted request yields a result D+1 cycles later.
    int             m_rem;
    logic           m_busy, m_done, m_cout, p_cout, m_err, p_err;
    logic [4*D-1:0] m_sum, p_sum;

    always @(posedge clk) begin
        if (rst) begin
            m_rem <= 0; m_busy <= 1'b0; m_done <= 1'b0;
            m_sum <= '0; m_cout <= 1'b0; m_err <= 1'b0;
        end else if (m_rem != 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_busy <= 1'b0; m_done <= 1'b1;
                m_sum <= p_sum; m_cout <= p_cout; m_err <= p_err;
            end
        end else if (start) begin
            m_rem <= D; m_busy <= 1'b1; m_done <= 1'b0;
            {p_cout, p_sum} <= ref_add(a, b, cin);
            p_err <= any_invalid(a, b);
        end else begin
            m_done <= 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", 64'(busy), 64'(m_busy));
            check("cyc_done", 64'(done), 64'(m_done));
            check("cyc_sum",  64'(sum),  64'(m_sum));
            check("cyc_cout", 64'(cout), 64'(m_cout));
`ifdef BCD_INVALID_CHECK_EN
            check("cyc_err",  64'(err),  64'(m_err));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [4*D-1:0] xa, input logic [4*D-1:0] xb, input logic xc,
                          input logic [4*D-1:0] exp_sum, input logic exp_cout);
        int cyc;
        step();
        a = xa; b = xb; cin = xc; start = 1'b1;
        step();
        start = 1'b0;
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("op_latency", 64'(cyc), 64'(D + 1));
        check("op_sum", 64'(sum), 64'(exp_sum));
        check("op_cout", 64'(cout), 64'(exp_cout));
        step();
    endtask

    initial begin
        int last, nd;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        step();
        step();
        cmp_en = 1'b1;
        rst = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'h0000);
        check("rst_cout", 64'(cout), 64'd0);

        run_op(16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1);
        run_op(16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1);
        run_op(16'h0456, 16'h0321, 1'b0, 16'h0777, 1'b0);
        run_op(16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0);

        // Back-to-back with start held high.
        step();
        a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
        last = -1; nd = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_sum", 64'(sum), 64'h0002);
                if (last >= 0) check("b2b_gap", 64'(k - last), 64'd5);
                last = k;
                nd++;
            end
        end
        check("b2b_count", 64'(nd), 64'd4);
        start = 1'b0;
        repeat (6) step();

        // Reset two cycles into a RUN aborts it.
        a = 16'h1234; b = 16'h8766; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum", 64'(sum), 64'h0000);
        check("abort_cout", 64'(cout), 64'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_nodone", 64'(done), 64'd0);
        end
        run_op(16'h0456, 16'h0321, 1'b0, 16'h0777, 1'b0);

`ifdef BCD_INVALID_CHECK_EN
        run_op(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0);
        check("err_set", 64'(err), 64'd1);
        run_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
        check("err_clr", 64'(err), 64'd0);
`endif

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
